fs_accel_wload_ctrl: RTL and testbench
======================================

Name: fs_accel_wload_ctrl

Overview:
- Sequences 3x3 kernel weight loading from the weight memory into the PE weight-register bank through the 3-way row weight demux (8-bit lanes, 2-bit row select).
- Each memory read returns one kernel row of three bytes. The controller fetches rows 0..2 and steers each to its row via the demux select. It then hands the complete kernel to the PE array with a valid/ack handshake and repeats for the configured number of kernels.
- Sits between the accelerator CSR/top FSM and the weight demux plus register bank.

Parameters:
ADDR_W, 16, weight-memory word address width (one word = one kernel row)
KCNT_W, 8, width of the kernel-count configuration and internal kernel counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a load job when idle
cfg_base_addr  in  ADDR_W  word address of row 0 of the first kernel; sampled on accepted start
cfg_num_kernels  in  KCNT_W  kernels to load; sampled on accepted start
busy  out  1  high from accepted start until the done cycle inclusive
done  out  1  one-cycle pulse at job end
mem_req  out  1  read request, held until mem_ack
mem_addr  out  ADDR_W  read address, stable while mem_req
mem_ack  in  1  one-cycle pulse; mem_rdata valid this cycle
mem_rdata  in  24  [7:0]=col0, [15:8]=col1, [23:16]=col2
wdemux_di_0/1/2  out  8 each  registered row bytes to demux inputs
wdemux_sel  out  2  row select 0..2; 3 = park (demux drives all zeros)
wreg_we  out  1  weight-bank write strobe for the row selected by wdemux_sel
kernel_valid  out  1  complete kernel present in bank; held until kernel_ack
kernel_ack  in  1  PE array consumed the kernel

Behaviour:
- Reset values (reset wins over all inputs, including mid-job): state IDLE; busy=0, done=0, mem_req=0, mem_addr=0, wdemux_di_*=0, wdemux_sel=3, wreg_we=0, kernel_valid=0; row and kernel counters 0.
- All outputs are registered.
- States: IDLE, REQ, WR, KVALID, DONE.
- IDLE:
  - start=1 with cfg_num_kernels!=0: latch config, mem_addr=cfg_base_addr, go to REQ. mem_req rises the next cycle.
  - start=1 with cfg_num_kernels==0: go directly to DONE; no memory traffic.
- REQ: mem_req=1. On mem_ack:
  - capture mem_rdata bytes into wdemux_di_0..2;
  - set wdemux_sel=row and wreg_we=1 for the next cycle;
  - drop mem_req;
  - go to WR.
  - mem_ack may arrive in the first REQ cycle, giving a 1-cycle minimum wait.
- WR: one cycle with wreg_we=1 (sel, di stable). Next cycle wreg_we=0, sel=3.
  - row<2: row++, mem_addr++, go to REQ.
  - row==2: row=0, mem_addr++, go to KVALID.
- KVALID: kernel_valid=1 until kernel_ack is sampled high. kernel_ack in the first KVALID cycle is accepted. Next cycle kernel_valid=0.
  - kernel counter == num-1: go to DONE.
  - otherwise: counter++, go to REQ.
- DONE: done=1 for one cycle, busy=1 in that cycle, then IDLE.
- Ignored inputs:
  - start while not IDLE.
  - mem_ack outside REQ.
  - kernel_ack outside KVALID.
- Kernel layout: consecutive kernels are contiguous, 3 words per kernel.
- mem_addr wraps modulo 2^ADDR_W with no error.
- Best-case throughput: 3 x (REQ+WR) + KVALID = 7 cycles per kernel.
- wreg_we is never high while wdemux_sel==3. wdemux_sel is 3 in every state except the WR cycle.

Decomposition:
- Shared package fs_accel_pkg holds:
  - state enum (IDLE, REQ, WR, KVALID, DONE);
  - constant WSEL_PARK=2'd3;
  - constant ROWS_PER_KERNEL=3.
- No sub-module needed. The 24-bit row capture register is inline.

Test Plan:
- Single kernel: base=0x0010, num=1, mem_ack 1 cycle after each req, rdata 0x030201/0x060504/0x090807 -> addresses 0x10,0x11,0x12; wreg_we pulses with sel=0,1,2 and di=(01,02,03),(04,05,06),(07,08,09); kernel_valid held until ack; done one cycle after ack cycle.
- num=0: start -> done pulse on 2nd cycle, busy high only in the done cycle, mem_req never asserted.
- Backpressure: num=2, mem_ack delayed 5 cycles, kernel_ack delayed 4 cycles -> mem_req and mem_addr held stable; kernel_valid stable; 6 reads at base..base+5 in order; exactly one done.
- Address wrap: ADDR_W=16, base=0xFFFF, num=1 -> addresses 0xFFFF, 0x0000, 0x0001.
- Reset mid-job: assert rst during the second REQ of kernel 0 -> next cycle all outputs at reset values, sel=3; a later start runs a clean job from the new base.
- Spurious inputs: start pulsed during KVALID, mem_ack pulsed in IDLE, kernel_ack pulsed during REQ -> no state, address or counter change.

Source files
------------

// File: rtl/fs_accel_pkg.sv
// Shared definitions for the accelerator weight-load path: controller states,
// the demux park select and the kernel geometry.
package fs_accel_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WR     = 3'd2,
        KVALID = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] WSEL_PARK       = 2'd3;
    localparam int         ROWS_PER_KERNEL = 3;

endpackage

// File: rtl/fs_accel_wload_ctrl.sv
// Weight-load controller: fetches 3x3 kernels one row per memory word, steers
// each row through the weight demux into the PE bank, then hands the kernel over.
module fs_accel_wload_ctrl
    import fs_accel_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int KCNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_cfg_base_addr,
    input  logic [KCNT_W-1:0] i_cfg_num_kernels,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [23:0]       i_mem_rdata,
    output logic [7:0]        o_wdemux_di_0,
    output logic [7:0]        o_wdemux_di_1,
    output logic [7:0]        o_wdemux_di_2,
    output logic [1:0]        o_wdemux_sel,
    output logic              o_wreg_we,
    output logic              o_kernel_valid,
    input  logic              i_kernel_ack,
    output logic [2:0]        o_dbg_state
);

    // Handshakes: mem_req/mem_addr are held until a one-cycle mem_ack is seen in
    // REQ; kernel_valid is held until kernel_ack is seen in KVALID. Acks arriving
    // in any other state are ignored.

    localparam logic [1:0] LAST_ROW = 2'(ROWS_PER_KERNEL - 1);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [23:0]       r_row_data;
    logic [1:0]        r_sel;
    logic              r_we;
    logic              r_kvalid;
    logic [1:0]        r_row;
    logic [KCNT_W-1:0] r_kcnt;
    logic [KCNT_W-1:0] r_num;

    state_t            w_state;
    logic              w_busy;
    logic              w_done;
    logic              w_mem_req;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [23:0]       w_row_data;
    logic [1:0]        w_sel;
    logic              w_we;
    logic              w_kvalid;
    logic [1:0]        w_row;
    logic [KCNT_W-1:0] w_kcnt;
    logic [KCNT_W-1:0] w_num;

    always_comb begin
        w_state    = r_state;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_mem_req  = r_mem_req;
        w_mem_addr = r_mem_addr;
        w_row_data = r_row_data;
        w_sel      = WSEL_PARK;
        w_we       = 1'b0;
        w_kvalid   = r_kvalid;
        w_row      = r_row;
        w_kcnt     = r_kcnt;
        w_num      = r_num;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_busy = 1'b1;
                    w_row  = 2'd0;
                    w_kcnt = '0;
                    w_num  = i_cfg_num_kernels;
                    if (i_cfg_num_kernels != '0) begin
                        w_mem_addr = i_cfg_base_addr;
                        w_mem_req  = 1'b1;
                        w_state    = REQ;
                    end else begin
                        w_done  = 1'b1;
                        w_state = DONE;
                    end
                end
            end
            REQ: begin
                if (i_mem_ack) begin
                    w_row_data = i_mem_rdata;
                    w_sel      = r_row;
                    w_we       = 1'b1;
                    w_mem_req  = 1'b0;
                    w_state    = WR;
                end
            end
            WR: begin
                // The address advances after every row, so kernels stay contiguous.
                w_mem_addr = r_mem_addr + ADDR_W'(1);
                if (r_row == LAST_ROW) begin
                    w_row    = 2'd0;
                    w_kvalid = 1'b1;
                    w_state  = KVALID;
                end else begin
                    w_row     = r_row + 2'd1;
                    w_mem_req = 1'b1;
                    w_state   = REQ;
                end
            end
            KVALID: begin
                if (i_kernel_ack) begin
                    w_kvalid = 1'b0;
                    if (r_kcnt == r_num - KCNT_W'(1)) begin
                        w_done  = 1'b1;
                        w_state = DONE;
                    end else begin
                        w_kcnt    = r_kcnt + KCNT_W'(1);
                        w_mem_req = 1'b1;
                        w_state   = REQ;
                    end
                end
            end
            DONE: begin
                w_busy  = 1'b0;
                w_kcnt  = '0;
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_row_data <= '0;
            r_sel      <= WSEL_PARK;
            r_we       <= 1'b0;
            r_kvalid   <= 1'b0;
            r_row      <= 2'd0;
            r_kcnt     <= '0;
            r_num      <= '0;
        end else begin
            r_state    <= w_state;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_mem_req  <= w_mem_req;
            r_mem_addr <= w_mem_addr;
            r_row_data <= w_row_data;
            r_sel      <= w_sel;
            r_we       <= w_we;
            r_kvalid   <= w_kvalid;
            r_row      <= w_row;
            r_kcnt     <= w_kcnt;
            r_num      <= w_num;
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_mem_req      = r_mem_req;
    assign o_mem_addr     = r_mem_addr;
    assign o_wdemux_di_0  = r_row_data[7:0];
    assign o_wdemux_di_1  = r_row_data[15:8];
    assign o_wdemux_di_2  = r_row_data[23:16];
    assign o_wdemux_sel   = r_sel;
    assign o_wreg_we      = r_we;
    assign o_kernel_valid = r_kvalid;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_fs_accel_wload_ctrl.sv
// Bench for the weight-load controller: memory and PE-array responders, a
// write/done monitor against expected queues, and directed job scenarios.
module tb_fs_accel_wload_ctrl;
    import fs_accel_pkg::*;

    localparam int ADDR_W = 16;
    localparam int KCNT_W = 8;

    logic              i_clk;
    logic              i_rst;
    logic              i_start;
    logic [ADDR_W-1:0] i_cfg_base_addr;
    logic [KCNT_W-1:0] i_cfg_num_kernels;
    logic              o_busy;
    logic              o_done;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_ack;
    logic [23:0]       i_mem_rdata;
    logic [7:0]        o_wdemux_di_0;
    logic [7:0]        o_wdemux_di_1;
    logic [7:0]        o_wdemux_di_2;
    logic [1:0]        o_wdemux_sel;
    logic              o_wreg_we;
    logic              o_kernel_valid;
    logic              i_kernel_ack;
    logic [2:0]        o_dbg_state;

    logic        resp_ack;
    logic        spur_mem_ack;
    logic        kack_drv;
    logic        spur_kack;
    logic [23:0] resp_rdata;
    logic [23:0] spur_rdata;

    assign i_mem_ack    = resp_ack | spur_mem_ack;
    assign i_mem_rdata  = resp_ack ? resp_rdata : spur_rdata;
    assign i_kernel_ack = kack_drv | spur_kack;

    int total          = 0;
    int bad            = 0;
    int cyc            = 0;
    int done_cnt       = 0;
    int kack_cnt       = 0;
    int exp_done_cycle = -1;
    int last_start_cyc = 0;
    int last_done_cyc  = 0;
    int ack_delay      = 0;
    int kack_delay     = 0;
    bit resp_en        = 1'b1;

    logic [ADDR_W-1:0] addr_q[$];
    logic [23:0]       rd_q[$];
    logic [25:0]       exp_q[$];

    fs_accel_wload_ctrl #(.ADDR_W(ADDR_W), .KCNT_W(KCNT_W)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_start           (i_start),
        .i_cfg_base_addr   (i_cfg_base_addr),
        .i_cfg_num_kernels (i_cfg_num_kernels),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_mem_req         (o_mem_req),
        .o_mem_addr        (o_mem_addr),
        .i_mem_ack         (i_mem_ack),
        .i_mem_rdata       (i_mem_rdata),
        .o_wdemux_di_0     (o_wdemux_di_0),
        .o_wdemux_di_1     (o_wdemux_di_1),
        .o_wdemux_di_2     (o_wdemux_di_2),
        .o_wdemux_sel      (o_wdemux_sel),
        .o_wreg_we         (o_wreg_we),
        .o_kernel_valid    (o_kernel_valid),
        .i_kernel_ack      (i_kernel_ack),
        .o_dbg_state       (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin : responder
        logic [ADDR_W-1:0] held;
        bit                aborted;
        resp_ack   = 1'b0;
        resp_rdata = '0;
        forever begin
            @(negedge i_clk);
            if (resp_en && o_mem_req) begin
                held    = o_mem_addr;
                aborted = 1'b0;
                for (int k = 0; k < ack_delay; k++) begin
                    @(negedge i_clk);
                    if (!resp_en) begin
                        aborted = 1'b1;
                        break;
                    end
                    chk("mem_req_hold", 32'(o_mem_req), 32'd1);
                    chk("mem_addr_hold", 32'(o_mem_addr), 32'(held));
                end
                if (!aborted) begin
                    chk("read_expected", 32'(addr_q.size() != 0), 32'd1);
                    if (addr_q.size() != 0) begin
                        chk("mem_addr", 32'(o_mem_addr), 32'(addr_q.pop_front()));
                        resp_rdata = rd_q.pop_front();
                    end
                    resp_ack = 1'b1;
                    @(negedge i_clk);
                    resp_ack = 1'b0;
                    chk("mem_req_drop", 32'(o_mem_req), 32'd0);
                end
            end
        end
    end

    // ---------------- PE-array responder ----------------
    initial begin : kack_driver
        kack_drv = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_kernel_valid) begin
                for (int k = 0; k < kack_delay; k++) begin
                    @(negedge i_clk);
                    chk("kvalid_hold", 32'(o_kernel_valid), 32'd1);
                end
                kack_drv       = 1'b1;
                exp_done_cycle = cyc + 1;
                @(negedge i_clk);
                kack_drv = 1'b0;
                kack_cnt++;
                chk("kvalid_drop", 32'(o_kernel_valid), 32'd0);
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [25:0] got;
        forever begin
            @(negedge i_clk);
            got = {o_wdemux_sel, o_wdemux_di_2, o_wdemux_di_1, o_wdemux_di_0};
            if (o_wreg_we) begin
                chk("we_sel_valid", 32'(o_wdemux_sel != WSEL_PARK), 32'd1);
                chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    chk("wr_row", 32'(got), 32'(exp_q.pop_front()));
            end else begin
                chk("sel_parked", 32'(o_wdemux_sel), 32'(WSEL_PARK));
            end
            if (o_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                chk("done_cycle", 32'(cyc), 32'(exp_done_cycle));
                chk("busy_in_done", 32'(o_busy), 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_row(input logic [ADDR_W-1:0] a, input logic [23:0] d, input logic [1:0] sel);
        addr_q.push_back(a);
        rd_q.push_back(d);
        exp_q.push_back({sel, d[23:16], d[15:8], d[7:0]});
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input logic [KCNT_W-1:0] num);
        @(negedge i_clk);
        i_cfg_base_addr   = base;
        i_cfg_num_kernels = num;
        i_start           = 1'b1;
        last_start_cyc    = cyc;
        if (num == '0) exp_done_cycle = cyc + 1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_mem_req", 32'(o_mem_req), 32'd0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_di", 32'({o_wdemux_di_2, o_wdemux_di_1, o_wdemux_di_0}), 32'd0);
        chk("rst_sel", 32'(o_wdemux_sel), 32'd3);
        chk("rst_we", 32'(o_wreg_we), 32'd0);
        chk("rst_kvalid", 32'(o_kernel_valid), 32'd0);
        chk("rst_state", 32'(o_dbg_state), 32'(IDLE));
    endtask

    task automatic finish_job(input int target, input int k0, input int num, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        chk("job_done", 32'(done_cnt), 32'(target));
        repeat (3) @(negedge i_clk);
        chk("one_done", 32'(done_cnt), 32'(target));
        chk("kernels_acked", 32'(kack_cnt - k0), 32'(num));
        chk("reads_left", 32'(addr_q.size()), 32'd0);
        chk("writes_left", 32'(exp_q.size()), 32'd0);
        chk("idle_state", 32'(o_dbg_state), 32'(IDLE));
        chk("idle_busy", 32'(o_busy), 32'd0);
    endtask

    task automatic run_job(input logic [ADDR_W-1:0] base, input int num, input int budget);
        int target;
        int k0;
        target = done_cnt + 1;
        k0     = kack_cnt;
        pulse_start(base, KCNT_W'(num));
        finish_job(target, k0, num, budget);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : main
        int n;
        int d0;
        int target;
        int k0;
        i_rst             = 1'b1;
        i_start           = 1'b1;
        i_cfg_base_addr   = 16'h1234;
        i_cfg_num_kernels = 8'd3;
        spur_mem_ack      = 1'b0;
        spur_kack         = 1'b0;
        spur_rdata        = '0;

        // reset wins even with start held high
        repeat (2) @(negedge i_clk);
        check_reset_outputs();
        i_rst   = 1'b0;
        i_start = 1'b0;
        @(negedge i_clk);
        chk("post_rst_idle", 32'(o_dbg_state), 32'(IDLE));

        // single kernel
        ack_delay  = 1;
        kack_delay = 2;
        push_row(16'h0010, 24'h030201, 2'd0);
        push_row(16'h0011, 24'h060504, 2'd1);
        push_row(16'h0012, 24'h090807, 2'd2);
        run_job(16'h0010, 1, 200);

        // zero kernels: straight to done, no reads
        chk("zero_busy_before", 32'(o_busy), 32'd0);
        pulse_start(16'h0040, 8'd0);
        chk("zero_done", 32'(o_done), 32'd1);
        chk("zero_busy", 32'(o_busy), 32'd1);
        chk("zero_no_req", 32'(o_mem_req), 32'd0);
        @(negedge i_clk);
        chk("zero_done_drop", 32'(o_done), 32'd0);
        chk("zero_busy_drop", 32'(o_busy), 32'd0);
        chk("zero_idle", 32'(o_dbg_state), 32'(IDLE));

        // backpressure on both handshakes, two kernels
        ack_delay  = 5;
        kack_delay = 4;
        push_row(16'h0100, 24'hA1B2C3, 2'd0);
        push_row(16'h0101, 24'h0F1E2D, 2'd1);
        push_row(16'h0102, 24'h102030, 2'd2);
        push_row(16'h0103, 24'hFFEE00, 2'd0);
        push_row(16'h0104, 24'h5A5A5A, 2'd1);
        push_row(16'h0105, 24'h00807F, 2'd2);
        run_job(16'h0100, 2, 400);

        // address wrap with zero-wait handshakes (best-case latency)
        ack_delay  = 0;
        kack_delay = 0;
        push_row(16'hFFFF, 24'h111111, 2'd0);
        push_row(16'h0000, 24'h222222, 2'd1);
        push_row(16'h0001, 24'h333333, 2'd2);
        run_job(16'hFFFF, 1, 200);
        chk("best_case_latency", 32'(last_done_cyc - last_start_cyc), 32'd8);

        // reset during the second row request
        ack_delay = 3;
        d0        = done_cnt;
        push_row(16'h0200, 24'h0A0B0C, 2'd0);
        push_row(16'h0201, 24'h0D0E0F, 2'd1);
        push_row(16'h0202, 24'h101112, 2'd2);
        pulse_start(16'h0200, 8'd1);
        n = 0;
        while (!(o_mem_req && o_mem_addr == 16'h0201) && n < 60) begin
            @(negedge i_clk);
            n++;
        end
        chk("reached_row1", 32'(o_mem_req && o_mem_addr == 16'h0201), 32'd1);
        #2;
        resp_en = 1'b0;
        i_rst   = 1'b1;
        @(negedge i_clk);
        check_reset_outputs();
        i_rst = 1'b0;
        addr_q.delete();
        rd_q.delete();
        exp_q.delete();
        resp_en = 1'b1;
        chk("no_done_on_reset", 32'(done_cnt), 32'(d0));

        ack_delay  = 1;
        kack_delay = 1;
        push_row(16'h0300, 24'h445566, 2'd0);
        push_row(16'h0301, 24'h778899, 2'd1);
        push_row(16'h0302, 24'hCCDDEE, 2'd2);
        run_job(16'h0300, 1, 200);

        // spurious mem_ack in IDLE
        @(negedge i_clk);
        spur_rdata   = 24'hABCDEF;
        spur_mem_ack = 1'b1;
        @(negedge i_clk);
        spur_mem_ack = 1'b0;
        chk("spur_mack_state", 32'(o_dbg_state), 32'(IDLE));
        chk("spur_mack_req", 32'(o_mem_req), 32'd0);
        chk("spur_mack_we", 32'(o_wreg_we), 32'd0);
        chk("spur_mack_di", 32'({o_wdemux_di_2, o_wdemux_di_1, o_wdemux_di_0}), 32'h00CCDDEE);

        // spurious kernel_ack in REQ and start in KVALID
        ack_delay  = 3;
        kack_delay = 3;
        push_row(16'h0400, 24'h123456, 2'd0);
        push_row(16'h0401, 24'h789ABC, 2'd1);
        push_row(16'h0402, 24'hDEF012, 2'd2);
        target = done_cnt + 1;
        k0     = kack_cnt;
        pulse_start(16'h0400, 8'd1);
        n = 0;
        while (!o_mem_req && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        spur_kack = 1'b1;
        @(negedge i_clk);
        spur_kack = 1'b0;
        chk("spur_kack_state", 32'(o_dbg_state), 32'(REQ));
        chk("spur_kack_addr", 32'(o_mem_addr), 32'h0400);
        chk("spur_kack_kvalid", 32'(o_kernel_valid), 32'd0);
        n = 0;
        while (!o_kernel_valid && n < 60) begin
            @(negedge i_clk);
            n++;
        end
        i_cfg_base_addr   = 16'h5000;
        i_cfg_num_kernels = 8'd5;
        i_start           = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("spur_start_state", 32'(o_dbg_state), 32'(KVALID));
        chk("spur_start_kvalid", 32'(o_kernel_valid), 32'd1);
        chk("spur_start_addr", 32'(o_mem_addr), 32'h0403);
        finish_job(target, k0, 1, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
